// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, padding-mode constants and sequencer state encoding
package conv_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int DIM_W_DEF   = 8;
  localparam int DEPTH_W_DEF = 9;
  localparam int NFILT_W_DEF = 4;
  localparam logic PAD_VALID = 1'b0;
  localparam logic PAD_SAME  = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/step_counter.sv
// step_counter: loadable up-counter with step, inclusive limit, wrap to init and carry-out
module step_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] init,
  input  logic [W-1:0] step,
  input  logic [W-1:0] max,
  output logic [W-1:0] nxt,
  output logic         co
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;
  always_comb begin
    wrap  = ({1'b0, cnt_q} + {1'b0, step}) > {1'b0, max};
    cnt_d = load ? init : en ? (wrap ? init : cnt_q + step) : cnt_q;
    co    = en & wrap & ~load;
  end
  assign nxt = cnt_d;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/conv_tap_sequencer.sv
// conv_tap_sequencer: multi-filter same/valid window tap address sequencer with ready/valid output
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DIM_W   = DIM_W_DEF,
  parameter int DEPTH_W = DEPTH_W_DEF,
  parameter int NFILT_W = NFILT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   image_dim,
  input  logic [DEPTH_W-1:0] image_depth,
  input  logic [ADDR_W-1:0]  image_memory_offset,
  input  logic [ADDR_W-1:0]  filter_memory_offset,
  input  logic [1:0]         filter_halfsize,
  input  logic [2:0]         filter_stride,
  input  logic [NFILT_W-1:0] filter_count,
  input  logic               pad_mode,
  output logic               busy,
  output logic               done,
  output logic               tap_valid,
  input  logic               tap_ready,
  output logic [ADDR_W-1:0]  tap_image_addr,
  output logic [ADDR_W-1:0]  tap_filter_addr,
  output logic               tap_pad,
  output logic               tap_first,
  output logic               tap_last,
  output logic [DIM_W-1:0]   out_row,
  output logic [DIM_W-1:0]   out_col,
  output logic [NFILT_W-1:0] out_filter
);
  state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic accept, fire, zero, same;
  logic [DIM_W-1:0] dim_q, dim_d, c0, cmax, rix_q, rix_d, cix_q, cix_d, row_d, col_d;
  logic [DEPTH_W-1:0] depth_q, depth_d, ch_d;
  logic [ADDR_W-1:0] ioff_q, ioff_d, foff_q, foff_d;
  logic [1:0] h_q, h_d;
  logic [2:0] s_q, s_d, s_eff, k, kmax, kx_d, ky_d;
  logic [NFILT_W-1:0] nf_q, nf_d, flt_q, flt_d;
  logic mode_q, mode_d;
  logic co_ch, co_kx, co_ky, co_col, co_row, co_flt;
  logic [ADDR_W-1:0] pitch, kd, flen, kstep, sd, sp, base0;
  logic [ADDR_W-1:0] p_q, p_d, wp_q, wp_d, rp_q, rp_d, fb_q, fb_d, fp_q, fp_d, img_q, img_d;
  logic [DIM_W:0] ry, rx, lo, hi;
  logic pad_q, pad_d, first_q, first_d, last_q, last_d;
  always_comb begin
    accept  = state_q == IDLE && start;
    fire    = valid_q && tap_ready;
    dim_d   = accept ? image_dim : dim_q;
    depth_d = accept ? image_depth : depth_q;
    ioff_d  = accept ? image_memory_offset : ioff_q;
    foff_d  = accept ? filter_memory_offset : foff_q;
    h_d     = accept ? filter_halfsize : h_q;
    s_d     = accept ? filter_stride : s_q;
    nf_d    = accept ? filter_count : nf_q;
    mode_d  = accept ? pad_mode : mode_q;
    same    = mode_d == PAD_SAME;
    s_eff   = s_d == 3'd0 ? 3'd1 : s_d;
    k       = {h_d, 1'b1};
    kmax    = {h_d, 1'b0};
    c0      = same ? '0 : DIM_W'(h_d);
    cmax    = same ? dim_d - DIM_W'(1) : dim_d - DIM_W'(1) - DIM_W'(h_d);
    zero    = depth_d == '0 || nf_d == '0 || dim_d == '0 || (!same && dim_d < DIM_W'(k));
    pitch   = ADDR_W'(dim_d) * ADDR_W'(depth_d);
    kd      = ADDR_W'(k) * ADDR_W'(depth_d);
    flen    = ADDR_W'(k) * kd;
    kstep   = pitch - kd + ADDR_W'(1);
    sd      = ADDR_W'(s_eff) * ADDR_W'(depth_d);
    sp      = ADDR_W'(s_eff) * pitch;
    base0   = same ? ioff_d - ADDR_W'(h_d) * (pitch + ADDR_W'(depth_d)) : ioff_d;
  end
  step_counter #(.W(DEPTH_W)) u_ch (
    .clk(clk), .rst(rst), .load(accept), .en(fire), .init('0), .step(DEPTH_W'(1)),
    .max(depth_d - DEPTH_W'(1)), .nxt(ch_d), .co(co_ch)
  );
  step_counter #(.W(3)) u_kx (
    .clk(clk), .rst(rst), .load(accept), .en(co_ch), .init('0), .step(3'd1),
    .max(kmax), .nxt(kx_d), .co(co_kx)
  );
  step_counter #(.W(3)) u_ky (
    .clk(clk), .rst(rst), .load(accept), .en(co_kx), .init('0), .step(3'd1),
    .max(kmax), .nxt(ky_d), .co(co_ky)
  );
  step_counter #(.W(DIM_W)) u_col (
    .clk(clk), .rst(rst), .load(accept), .en(co_ky), .init(c0), .step(DIM_W'(s_eff)),
    .max(cmax), .nxt(col_d), .co(co_col)
  );
  step_counter #(.W(DIM_W)) u_row (
    .clk(clk), .rst(rst), .load(accept), .en(co_col), .init(c0), .step(DIM_W'(s_eff)),
    .max(cmax), .nxt(row_d), .co(co_row)
  );
  step_counter #(.W(NFILT_W)) u_flt (
    .clk(clk), .rst(rst), .load(accept), .en(co_row), .init('0), .step(NFILT_W'(1)),
    .max(nf_d - NFILT_W'(1)), .nxt(flt_d), .co(co_flt)
  );
  always_comb begin
    ry      = {1'b0, row_d} + (DIM_W+1)'(ky_d);
    rx      = {1'b0, col_d} + (DIM_W+1)'(kx_d);
    lo      = (DIM_W+1)'(h_d);
    hi      = {1'b0, dim_d} + (DIM_W+1)'(h_d);
    pad_d   = ry < lo || ry >= hi || rx < lo || rx >= hi;
    first_d = ch_d == '0 && kx_d == '0 && ky_d == '0;
    last_d  = ch_d == depth_d - DEPTH_W'(1) && kx_d == kmax && ky_d == kmax;
    p_d     = p_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    fb_d    = fb_q;
    fp_d    = fp_q;
    if (accept) begin
      p_d  = base0;
      wp_d = base0;
      rp_d = base0;
      fb_d = foff_d;
      fp_d = foff_d;
    end else if (fire) begin
      if (co_row) begin
        fb_d = fb_q + flen;
        fp_d = fb_d;
        p_d  = base0;
        wp_d = base0;
        rp_d = base0;
      end else if (co_col) begin
        rp_d = rp_q + sp;
        wp_d = rp_d;
        p_d  = rp_d;
        fp_d = fb_q;
      end else if (co_ky) begin
        wp_d = wp_q + sd;
        p_d  = wp_d;
        fp_d = fb_q;
      end else begin
        fp_d = fp_q + ADDR_W'(1);
        p_d  = co_kx ? p_q + kstep : p_q + ADDR_W'(1);
      end
    end
    img_d   = pad_d ? '0 : p_d;
    cix_d   = (accept || (fire && co_col)) ? '0 : (fire && co_ky) ? cix_q + DIM_W'(1) : cix_q;
    rix_d   = (accept || (fire && co_row)) ? '0 : (fire && co_col) ? rix_q + DIM_W'(1) : rix_q;
    state_d = state_q == IDLE ? (start ? (zero ? DONE : RUN) : IDLE)
            : state_q == RUN  ? ((fire && co_flt) ? DONE : RUN)
            : IDLE;
    busy_d  = state_d == RUN;
    valid_d = state_d == RUN;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= '0;
      done_q  <= '0;
      valid_q <= '0;
      dim_q   <= '0;
      depth_q <= '0;
      ioff_q  <= '0;
      foff_q  <= '0;
      h_q     <= '0;
      s_q     <= '0;
      nf_q    <= '0;
      mode_q  <= '0;
      p_q     <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fb_q    <= '0;
      fp_q    <= '0;
      img_q   <= '0;
      pad_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      rix_q   <= '0;
      cix_q   <= '0;
      flt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      dim_q   <= dim_d;
      depth_q <= depth_d;
      ioff_q  <= ioff_d;
      foff_q  <= foff_d;
      h_q     <= h_d;
      s_q     <= s_d;
      nf_q    <= nf_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fb_q    <= fb_d;
      fp_q    <= fp_d;
      img_q   <= img_d;
      pad_q   <= pad_d;
      first_q <= first_d;
      last_q  <= last_d;
      rix_q   <= rix_d;
      cix_q   <= cix_d;
      flt_q   <= flt_d;
    end
  end
  assign busy            = busy_q;
  assign done            = done_q;
  assign tap_valid       = valid_q;
  assign tap_image_addr  = img_q;
  assign tap_filter_addr = fp_q;
  assign tap_pad         = pad_q;
  assign tap_first       = first_q;
  assign tap_last        = last_q;
  assign out_row         = rix_q;
  assign out_col         = cix_q;
  assign out_filter      = flt_q;
endmodule

// File: tb/tb_conv_tap_sequencer.sv
// tb_conv_tap_sequencer: directed vector table plus stall and reset sequences for conv_tap_sequencer
module tb_conv_tap_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, tap_ready, pad_mode;
  logic [7:0]  image_dim;
  logic [8:0]  image_depth;
  logic [15:0] image_memory_offset, filter_memory_offset;
  logic [1:0]  filter_halfsize;
  logic [2:0]  filter_stride;
  logic [3:0]  filter_count;
  logic        busy, done, tap_valid, tap_pad, tap_first, tap_last;
  logic [15:0] tap_image_addr, tap_filter_addr;
  logic [7:0]  out_row, out_col;
  logic [3:0]  out_filter;
  conv_tap_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .image_dim(image_dim), .image_depth(image_depth),
    .image_memory_offset(image_memory_offset), .filter_memory_offset(filter_memory_offset),
    .filter_halfsize(filter_halfsize), .filter_stride(filter_stride), .filter_count(filter_count),
    .pad_mode(pad_mode), .busy(busy), .done(done), .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_image_addr(tap_image_addr), .tap_filter_addr(tap_filter_addr), .tap_pad(tap_pad),
    .tap_first(tap_first), .tap_last(tap_last), .out_row(out_row), .out_col(out_col),
    .out_filter(out_filter)
  );
  always #5 clk = ~clk;
  typedef struct {
    int dim, depth, h, s, nf, mode, ioff, foff, taps, probe;
    logic [63:0] pexp;
  } vec_t;
  vec_t vt[10];
  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  function automatic logic [63:0] pk(int img, int flt, int pad, int first, int last, int row, int col, int filt);
    return {9'b0, 16'(img), 16'(flt), 1'(pad), 1'(first), 1'(last), 8'(row), 8'(col), 4'(filt)};
  endfunction
  function automatic logic [63:0] obs();
    return pk(int'(tap_image_addr), int'(tap_filter_addr), int'(tap_pad), int'(tap_first),
              int'(tap_last), int'(out_row), int'(out_col), int'(out_filter));
  endfunction
  function automatic logic [63:0] flags();
    return 64'({busy, done, tap_valid});
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic build(input vec_t v);
    int s, k, l, c0, lim, ri, ci, py, px, pad, img, flt;
    exp_q.delete();
    s   = v.s == 0 ? 1 : v.s;
    k   = 2 * v.h + 1;
    l   = k * k * v.depth;
    c0  = v.mode ? 0 : v.h;
    lim = v.mode ? v.dim - 1 : v.dim - 1 - v.h;
    for (int f = 0; f < v.nf; f++) begin
      ri = 0;
      for (int r = c0; r <= lim; r += s) begin
        ci = 0;
        for (int c = c0; c <= lim; c += s) begin
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              for (int ch = 0; ch < v.depth; ch++) begin
                py  = r + ky - v.h;
                px  = c + kx - v.h;
                pad = (py < 0 || py >= v.dim || px < 0 || px >= v.dim) ? 1 : 0;
                img = pad ? 0 : v.ioff + (py * v.dim + px) * v.depth + ch;
                flt = v.foff + f * l + (ky * k + kx) * v.depth + ch;
                exp_q.push_back(pk(img, flt, pad, (ky == 0 && kx == 0 && ch == 0) ? 1 : 0,
                                   (ky == k - 1 && kx == k - 1 && ch == v.depth - 1) ? 1 : 0, ri, ci, f));
              end
          ci++;
        end
        ri++;
      end
    end
  endtask
  task automatic apply_cfg(input vec_t v);
    image_dim            = 8'(v.dim);
    image_depth          = 9'(v.depth);
    image_memory_offset  = 16'(v.ioff);
    filter_memory_offset = 16'(v.foff);
    filter_halfsize      = 2'(v.h);
    filter_stride        = 3'(v.s);
    filter_count         = 4'(v.nf);
    pad_mode             = 1'(v.mode);
  endtask
  task automatic scramble();
    image_dim            = 8'($urandom);
    image_depth          = 9'($urandom);
    image_memory_offset  = 16'($urandom);
    filter_memory_offset = 16'($urandom);
    filter_halfsize      = 2'($urandom);
    filter_stride        = 3'($urandom);
    filter_count         = 4'($urandom);
    pad_mode             = 1'($urandom);
  endtask
  task automatic run(input vec_t v, input string nm, input int stall_at, input int rst_at, output int cycles);
    int taps, stall;
    logic seen;
    build(v);
    apply_cfg(v);
    start     = 1'b1;
    tap_ready = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    scramble();
    cycles = 1;
    taps   = 0;
    stall  = 0;
    if (v.taps == 0) begin
      chk({nm, ".zero_done"}, flags(), 64'b010);
      @(negedge clk);
      chk({nm, ".zero_after"}, flags(), 64'b000);
      return;
    end
    chk({nm, ".start_flags"}, flags(), 64'b101);
    for (int b = 0; b < 4000 && !done; b++) begin
      if (tap_valid && taps < exp_q.size()) begin
        if (taps == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk({nm, ".rst_flags"}, flags(), 64'b000);
          chk({nm, ".rst_fields"}, obs(), 64'h0);
          seen = 1'b0;
          repeat (6) begin
            @(negedge clk);
            seen = seen | done;
          end
          chk({nm, ".rst_no_done"}, 64'(seen), 64'h0);
          return;
        end else if (taps == stall_at && stall < 3) begin
          tap_ready = 1'b0;
          chk($sformatf("%s.stall%0d", nm, stall), obs(), exp_q[taps]);
          stall++;
        end else begin
          tap_ready = 1'b1;
          chk($sformatf("%s.tap%0d", nm, taps), obs(), exp_q[taps]);
          if (taps == v.probe) chk({nm, ".probe"}, obs(), v.pexp);
          taps++;
        end
      end
      @(negedge clk);
      cycles++;
    end
    chk({nm, ".done_seen"}, 64'(done), 64'h1);
    chk({nm, ".busy_in_done"}, 64'(busy), 64'h0);
    chk({nm, ".tap_count"}, 64'(taps), 64'(v.taps));
    apply_cfg(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".start_in_done_ignored"}, flags(), 64'b000);
  endtask
  initial begin
    int cyc;
    rst       = 1'b1;
    start     = 1'b0;
    tap_ready = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("reset_flags", flags(), 64'b000);
    chk("reset_fields", obs(), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_flags", flags(), 64'b000);
    vt[0] = '{5, 3, 1, 1, 1, 1, 0, 1000, 675, 0, pk(0, 1000, 1, 1, 0, 0, 0, 0)};
    vt[1] = '{5, 3, 1, 1, 1, 1, 0, 1000, 675, 12, pk(0, 1012, 0, 0, 0, 0, 0, 0)};
    vt[2] = '{5, 3, 1, 2, 1, 0, 0, 1000, 108, 107, pk(74, 1026, 0, 0, 1, 1, 1, 0)};
    vt[3] = '{5, 3, 1, 1, 2, 1, 0, 1000, 1350, 675, pk(0, 1027, 1, 1, 0, 0, 0, 1)};
    vt[4] = '{2, 3, 1, 1, 1, 0, 0, 1000, 0, -1, 64'h0};
    vt[5] = '{5, 0, 1, 1, 1, 1, 0, 1000, 0, -1, 64'h0};
    vt[6] = '{5, 3, 1, 1, 0, 1, 0, 1000, 0, -1, 64'h0};
    vt[7] = '{4, 1, 0, 0, 1, 1, 100, 200, 16, 15, pk(115, 200, 0, 1, 1, 3, 3, 0)};
    vt[8] = '{3, 2, 2, 3, 1, 1, 'hFFF0, 'hFFFE, 50, 49, pk(1, 'h2F, 0, 0, 1, 0, 0, 0)};
    vt[9] = '{7, 1, 3, 1, 1, 0, 0, 0, 49, 24, pk(24, 24, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      run(vt[i], $sformatf("v%0d", i), -1, -1, cyc);
      if (vt[i].taps > 0) chk($sformatf("v%0d.cycles", i), 64'(cyc), 64'(vt[i].taps + 1));
    end
    run(vt[0], "stall", 10, -1, cyc);
    chk("stall.cycles", 64'(cyc), 64'(675 + 1 + 3));
    run(vt[0], "rst", -1, 50, cyc);
    run(vt[0], "replay", -1, -1, cyc);
    chk("replay.cycles", 64'(cyc), 64'(676));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
